// File: rtl/norm_lzc_seq_if.sv
// Handshake/data bundle between an FPU post-processing stage and the
// sequential leading-zero counter (norm_lzc_seq).
//   master: operand producer and result consumer
//   slave : norm_lzc_seq itself
interface norm_lzc_seq_if #(
  parameter int NORMSHIFTSZ    = 116,
  parameter int LOGNORMSHIFTSZ = $clog2(NORMSHIFTSZ)
);
  logic                      Flush;
  logic                      InValid;
  logic                      InReady;
  logic [NORMSHIFTSZ-1:0]    OpIn;
  logic [LOGNORMSHIFTSZ-1:0] MaxShift;
  logic                      OutValid;
  logic                      OutReady;
  logic [NORMSHIFTSZ-1:0]    ShiftIn;
  logic [LOGNORMSHIFTSZ-1:0] ShiftAmt;
  logic                      AllZero;

  modport master (
    output Flush, InValid, OpIn, MaxShift, OutReady,
    input  InReady, OutValid, ShiftIn, ShiftAmt, AllZero
  );

  modport slave (
    input  Flush, InValid, OpIn, MaxShift, OutReady,
    output InReady, OutValid, ShiftIn, ShiftAmt, AllZero
  );
endinterface

// File: rtl/norm_lzc_seq.sv
// Sequential leading-zero counter for the normalization shifter.
// Scans the captured significand MSB-first, CHUNK bits per cycle, and
// reports min(leading zeros, MaxShift) together with the operand itself.
// Optional feature macro: NORMLZC_PIPE_EN -- accept the next operand in the
// same cycle the current result is handed off (no IDLE bubble).
module norm_lzc_seq #(
  parameter int NORMSHIFTSZ    = 116,
  parameter int LOGNORMSHIFTSZ = $clog2(NORMSHIFTSZ),
  parameter int CHUNK          = 4
) (
  input  logic          clk,
  input  logic          reset,
  norm_lzc_seq_if.slave lzc_if
);

  // Operand is zero-padded at the LSB end up to a whole number of chunks.
  localparam int NCHUNKS = (NORMSHIFTSZ + CHUNK - 1) / CHUNK;
  localparam int PADW    = NCHUNKS * CHUNK;
  localparam int IW      = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
  localparam int CW      = $clog2(CHUNK + 1);
  // One extra bit so the count of a fully padded zero operand cannot wrap.
  localparam int CNTW    = LOGNORMSHIFTSZ + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  state_e                    state_q;
  logic [NORMSHIFTSZ-1:0]    op_q;
  logic [LOGNORMSHIFTSZ-1:0] max_q;
  logic [LOGNORMSHIFTSZ-1:0] amt_q;
  logic                      allzero_q;
  logic                      out_valid_q;
  logic [CNTW-1:0]           cnt_q;
  logic [IW-1:0]             idx_q;

  logic [PADW-1:0]           op_pad;
  logic [PADW-1:0]           chunk_win;
  logic [CHUNK-1:0]          chunk;
  logic [CW-1:0]             chunk_lz;
  logic                      chunk_nz;
  logic                      last_chunk;
  logic                      clamp_hit;
  logic                      scan_stop;
  logic [CNTW-1:0]           cnt_d;
  logic [IW-1:0]             idx_d;
  logic [LOGNORMSHIFTSZ-1:0] amt_d;
  logic                      in_ready;
  logic                      accept;
  logic                      out_fire;

  // Handshake qualifiers; a flush always wins over a capture.
`ifdef NORMLZC_PIPE_EN
  assign in_ready = ((state_q == S_IDLE) |
                     ((state_q == S_DONE) & lzc_if.OutReady)) & ~reset;
`else
  assign in_ready = (state_q == S_IDLE) & ~reset;
`endif
  assign accept   = lzc_if.InValid & in_ready & ~lzc_if.Flush;
  assign out_fire = out_valid_q & lzc_if.OutReady;

  // Current chunk, its leading-zero count and the resulting scan decision.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    op_pad    = PADW'(op_q) << (PADW - NORMSHIFTSZ);
    chunk_win = op_pad << (idx_q * CHUNK);
    chunk     = chunk_win[PADW-1 -: CHUNK];
    chunk_nz  = |chunk;
    chunk_lz  = CW'(CHUNK);
    // Lowest to highest, so the most significant set bit wins.
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) chunk_lz = CW'(CHUNK - 1 - i);
    end
    cnt_d      = cnt_q + (chunk_nz ? CNTW'(chunk_lz) : CNTW'(CHUNK));
    idx_d      = idx_q + IW'(1);
    last_chunk = (idx_q == LAST_IDX);
    clamp_hit  = (cnt_d >= {1'b0, max_q});
    scan_stop  = chunk_nz | clamp_hit | last_chunk;
    // Below the clamp the count is < MaxShift, so it fits the narrower width.
    amt_d      = clamp_hit ? max_q : cnt_d[LOGNORMSHIFTSZ-1:0];
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before this edge, independent of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      max_q       <= '0;
      amt_q       <= '0;
      allzero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
    end else if (lzc_if.Flush) begin
      // Abort: results already registered stay visible, only validity drops.
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      // Reached from IDLE, or from DONE during the output handshake when the
      // back-to-back option makes in_ready true there.
      state_q     <= S_SCAN;
      op_q        <= lzc_if.OpIn;
      max_q       <= lzc_if.MaxShift;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_SCAN: begin
          cnt_q <= cnt_d;
          idx_q <= idx_d;
          if (scan_stop) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            amt_q       <= amt_d;
            // Reaching the last chunk with it still zero means every chunk
            // was zero; an earlier clamp stop never gets here.
            allzero_q   <= last_chunk & ~chunk_nz;
          end
        end
        S_DONE: begin
          if (out_fire) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lzc_if.InReady  = in_ready;
  assign lzc_if.OutValid = out_valid_q;
  assign lzc_if.ShiftIn  = op_q;
  assign lzc_if.ShiftAmt = amt_q;
  assign lzc_if.AllZero  = allzero_q;

endmodule
